// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller.
// Segment patterns are Pabcdefg, active-high.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [7:0] HEX7_TABLE [16] = '{
        8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
        8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to Pabcdefg segment pattern lookup.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    assign seg_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot counter, dead time, PWM brightness and a
// shadow register that only reaches the display at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG        = 2,
    parameter int unsigned SLOT_LOG2   = 16,
    parameter int unsigned DEAD_CYCLES = 256,
    localparam int unsigned DIG_W      = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                fastclk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [3:0]          bright,
    output logic [7:0]          seg,
    output logic                seg_en,
    output logic [DIG_W-1:0]    digit,
    output logic                io_select,
    output logic                frame_tick
);

    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NDIG - 1);

    logic [SLOT_LOG2-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic [4*NDIG-1:0]    shadow_q, shadow_d;
    logic [4*NDIG-1:0]    active_q, active_d;
    logic                 empty_q, empty_d;
    logic [7:0]           seg_q, seg_d;
    logic                 seg_en_q, seg_en_d;
    logic                 io_select_q, io_select_d;
    logic                 frame_tick_q, frame_tick_d;

    logic                 slot_end;
    logic                 frame_end;
    logic [3:0]           nibble_d;
    logic [7:0]           dec_seg;

    hex7seg_dec u_dec (
        .nibble_i (nibble_d),
        .seg_o    (dec_seg)
    );

    always_comb begin
        slot_end  = &cnt_q;
        frame_end = slot_end && (digit_q == LAST_DIG);
        cnt_d     = cnt_q + SLOT_LOG2'(1);

        digit_d = digit_q;
        if (slot_end) begin
            digit_d = (digit_q == LAST_DIG) ? '0 : digit_q + DIG_W'(1);
        end

        // Shadow is never full while accepting, so apply and capture cannot collide.
        shadow_d = shadow_q;
        active_d = active_q;
        empty_d  = empty_q;
        if (frame_end && !empty_q) begin
            active_d = shadow_q;
            empty_d  = 1'b1;
        end
        if (din_valid && empty_q) begin
            shadow_d = din;
            empty_d  = 1'b0;
        end

        // Outputs are computed from next-state so every pin is a plain flop.
        nibble_d = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (digit_d == DIG_W'(i)) begin
                nibble_d = active_d[4*(NDIG-1-i) +: 4];
            end
        end

        seg_en_d = (cnt_d >= SLOT_LOG2'(DEAD_CYCLES)) &&
                   (cnt_d[SLOT_LOG2-1 -: 4] < bright);
        seg_d        = seg_en_d ? dec_seg : SEG_BLANK;
        io_select_d  = digit_d[0];
        frame_tick_d = (&cnt_d) && (digit_d == LAST_DIG);
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            empty_q      <= 1'b1;
            seg_q        <= SEG_BLANK;
            seg_en_q     <= 1'b0;
            io_select_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            empty_q      <= empty_d;
            seg_q        <= seg_d;
            seg_en_q     <= seg_en_d;
            io_select_q  <= io_select_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign seg_en     = seg_en_q;
    assign digit      = digit_q;
    assign io_select  = io_select_q;
    assign frame_tick = frame_tick_q;
    assign din_ready  = empty_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with NDIG=2, SLOT_LOG2=6, DEAD_CYCLES=4: time-based reference
// model checked every cycle, plus vector tables and directed corner sequences.
module tb_seg7_scan_ctrl;

    localparam int NDIG  = 2;
    localparam int SLOT  = 64;
    localparam int FRAME = SLOT * NDIG;
    localparam int DEAD  = 4;

    logic       fastclk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] bright;
    logic [7:0] seg;
    logic       seg_en;
    logic [0:0] digit;
    logic       io_select;
    logic       frame_tick;

    always #5 fastclk = ~fastclk;

    seg7_scan_ctrl #(
        .NDIG        (2),
        .SLOT_LOG2   (6),
        .DEAD_CYCLES (4)
    ) dut (
        .fastclk    (fastclk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .bright     (bright),
        .seg        (seg),
        .seg_en     (seg_en),
        .digit      (digit),
        .io_select  (io_select),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] s0;
        logic [7:0] s1;
    } hex_vec_t;

    typedef struct {
        logic [3:0] b;
        int         lit;
    } pwm_vec_t;

    int total;
    int bad;

    // Reference model: absolute cycle count since reset plus display data registers.
    int         t;
    logic [7:0] m_active;
    logic [7:0] m_shadow;
    bit         m_full;
    int         m_bright;

    function automatic logic [7:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'h7E;  4'h1: return 8'h30;  4'h2: return 8'h6D;  4'h3: return 8'h79;
            4'h4: return 8'h33;  4'h5: return 8'h5B;  4'h6: return 8'h5F;  4'h7: return 8'h70;
            4'h8: return 8'h7F;  4'h9: return 8'h7B;  4'hA: return 8'h77;  4'hB: return 8'h1F;
            4'hC: return 8'h4E;  4'hD: return 8'h3D;  4'hE: return 8'h4F;  default: return 8'h47;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
        end
    endtask

    task automatic model_check();
        int         pos;
        int         dig;
        bit         lit;
        logic [3:0] nib;
        logic [7:0] eseg;
        pos  = t % SLOT;
        dig  = (t / SLOT) % NDIG;
        lit  = (pos >= DEAD) && ((pos * 16 / SLOT) < m_bright);
        nib  = (dig == 0) ? m_active[7:4] : m_active[3:0];
        eseg = lit ? ref_seg(nib) : 8'h00;
        chk("model", {seg, seg_en, digit, io_select, frame_tick, din_ready},
            {eseg, lit, 1'(dig), 1'(dig % 2), (t % FRAME) == FRAME - 1, !m_full});
    endtask

    task automatic step();
        bit accept;
        @(posedge fastclk);
        accept = din_valid && !m_full;
        if ((t % FRAME) == FRAME - 1 && m_full) begin
            m_active = m_shadow;
            m_full   = 1'b0;
        end
        if (accept) begin
            m_shadow = din;
            m_full   = 1'b1;
        end
        m_bright = int'(bright);
        t++;
        #1;
        model_check();
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic run_to_pos(input int modulus, input int rem);
        while ((t % modulus) != rem) step();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge fastclk);
        #1;
        rst_n    = 1'b1;
        t        = 0;
        m_full   = 1'b0;
        m_active = 8'h00;
        m_shadow = 8'h00;
        m_bright = int'(bright);
        model_check();
    endtask

    hex_vec_t hex_vecs [8];
    pwm_vec_t pwm_vecs [4];

    initial begin
        int base;
        int cnt;
        int n;

        hex_vecs[0] = '{8'h01, 8'h7E, 8'h30};
        hex_vecs[1] = '{8'h23, 8'h6D, 8'h79};
        hex_vecs[2] = '{8'h45, 8'h33, 8'h5B};
        hex_vecs[3] = '{8'h67, 8'h5F, 8'h70};
        hex_vecs[4] = '{8'h89, 8'h7F, 8'h7B};
        hex_vecs[5] = '{8'hAB, 8'h77, 8'h1F};
        hex_vecs[6] = '{8'hCD, 8'h4E, 8'h3D};
        hex_vecs[7] = '{8'hEF, 8'h4F, 8'h47};
        pwm_vecs[0] = '{4'd0, 0};
        pwm_vecs[1] = '{4'd1, 0};
        pwm_vecs[2] = '{4'd8, 28};
        pwm_vecs[3] = '{4'd15, 56};

        total     = 0;
        bad       = 0;
        t         = 0;
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        bright    = 4'd15;
        #3;
        release_reset();

        // Reset state and first slot of digit 0 showing "0".
        chk("reset_seg", seg, 8'h00);
        chk("reset_seg_en", seg_en, 1'b0);
        chk("reset_digit", digit, 1'b0);
        chk("reset_ready", din_ready, 1'b1);
        run_to(3);
        chk("dead_time_blank", seg, 8'h00);
        run_to(4);
        chk("first_lit", seg, 8'h7E);
        run_to(59);
        chk("last_lit", seg, 8'h7E);
        run_to(60);
        chk("pwm_off_at_60", seg_en, 1'b0);

        // Load A5 in frame 0, visible from frame 1.
        din       = 8'hA5;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("load_ready_low", din_ready, 1'b0);
        run_to(127);
        chk("frame_tick_127", frame_tick, 1'b1);
        run_to(128);
        chk("ready_after_tick", din_ready, 1'b1);
        run_to(148);
        chk("a5_digit0", {seg, io_select}, {8'h77, 1'b0});
        run_to(212);
        chk("a5_digit1", {seg, io_select}, {8'h5B, 1'b1});

        // Refill with A5, then offer 3C while shadow is full.
        din       = 8'hA5;
        din_valid = 1'b1;
        step();
        din       = 8'h3C;
        step();
        chk("held_off", din_ready, 1'b0);
        run_to(255);
        chk("held_off_to_tick", din_ready, 1'b0);
        run_to(256);
        chk("ready_at_frame2", din_ready, 1'b1);
        step();
        din_valid = 1'b0;
        chk("3c_captured", din_ready, 1'b0);
        run_to(276);
        chk("a5_one_more_frame", seg, 8'h77);
        run_to(404);
        chk("3c_digit0", seg, 8'h79);
        run_to(468);
        chk("3c_digit1", seg, 8'h4E);

        // Brightness table: lit cycles over one full slot.
        foreach (pwm_vecs[i]) begin
            run_to_pos(SLOT, SLOT - 1);
            bright = pwm_vecs[i].b;
            cnt    = 0;
            repeat (SLOT) begin
                step();
                if (seg_en) cnt++;
                if (seg != 8'h00 && !seg_en) cnt += 1000;
            end
            chk("pwm_lit_count", cnt, pwm_vecs[i].lit);
        end
        bright = 4'd15;

        // Capture on the frame_tick cycle itself lands one frame later.
        run_to_pos(FRAME, FRAME - 1);
        chk("on_tick", {frame_tick, din_ready}, 2'b11);
        din       = 8'h12;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        base      = t;
        chk("tick_capture", din_ready, 1'b0);
        run_to(base + 20);
        chk("tick_capture_not_yet", seg, 8'h79);
        run_to(base + FRAME + 20);
        chk("12_digit0", seg, 8'h30);
        run_to(base + FRAME + SLOT + 20);
        chk("12_digit1", seg, 8'h6D);

        // Mid-slot reset with shadow full.
        din       = 8'h88;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run_to_pos(SLOT, 20);
        chk("pre_reset_lit", seg_en, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {seg, seg_en, digit, io_select, frame_tick, din_ready},
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        release_reset();
        run_to(20);
        chk("after_reset_d0", seg, 8'h7E);
        run_to(84);
        chk("after_reset_d1", seg, 8'h7E);
        run_to(148);
        chk("shadow_discarded", seg, 8'h7E);

        // Hex decode table through the full load path.
        foreach (hex_vecs[i]) begin
            n = 0;
            while (!din_ready && n < 300) begin
                step();
                n++;
            end
            chk("hex_ready_wait", din_ready, 1'b1);
            din       = hex_vecs[i].d;
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            base      = ((t / FRAME) + 1) * FRAME;
            run_to(base + 20);
            chk("hex_digit0", seg, hex_vecs[i].s0);
            run_to(base + SLOT + 20);
            chk("hex_digit1", seg, hex_vecs[i].s1);
        end

        // Random traffic against the model.
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
            if (!(din_valid && m_full)) begin
                din_valid = ($urandom_range(0, 3) == 0);
                din       = 8'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
